// File: rtl/fetch.sv
// fetch: single-issue instruction fetch stage feeding the IF/ID pipeline register.
// Define FETCH_STALL_CNT_EN to build the saturating imem wait-cycle counter on o_stall_cnt.
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [1:0]  i_pcsrc,
    input  logic [31:0] i_nextPC,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_imem_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_Rs,
    output logic [4:0]  o_Rt,
    output logic [4:0]  o_Rd,
    output logic [25:0] o_imm,
    output logic [31:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] drain_addr_r;
    logic [31:0] buf_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_instr_r;
    logic        ifid_valid_r;

    logic        redirect_s;
    logic [31:0] redirect_pc_s;
    logic        req_s;
    logic        load_mem_s;
    logic        load_buf_s;
    logic        capture_buf_s;
    logic        enter_drain_s;

    // A redirect presented during a stall is ignored; decode re-presents it later.
    assign redirect_s    = (i_pcsrc != 2'b00) && !i_stall;
    assign redirect_pc_s = i_nextPC & 32'hFFFF_FFFC;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a flush never moves the FSM, but an in-flight drain still completes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (redirect_s) begin
                    state_nxt_s = i_imem_ready ? ST_FETCH : ST_DRAIN;
                end else if (!i_flush && i_imem_ready && i_stall) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_s || (!i_stall && !i_flush)) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (i_imem_ready) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // Output and datapath-control decode per state.
    always_comb begin
        req_s         = 1'b0;
        o_imem_addr   = pc_r;
        load_mem_s    = 1'b0;
        load_buf_s    = 1'b0;
        capture_buf_s = 1'b0;
        enter_drain_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                req_s = 1'b1;
                if (i_imem_ready && !redirect_s && !i_flush) begin
                    load_mem_s    = !i_stall;
                    capture_buf_s = i_stall;
                end else begin
                    enter_drain_s = redirect_s && !i_imem_ready;
                end
            end
            ST_HOLD: begin
                load_buf_s = !i_stall && !redirect_s && !i_flush;
            end
            ST_DRAIN: begin
                req_s       = 1'b1;
                o_imem_addr = drain_addr_r;
            end
            default: req_s = 1'b0;
        endcase
    end

    // The request is masked while reset is held so no access escapes during reset.
    assign o_imem_req = req_s && i_rst_n;

    // PC, holding buffer and the address of a request being drained.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r         <= RESET_PC;
            buf_r        <= 32'h0000_0000;
            drain_addr_r <= 32'h0000_0000;
        end else begin
            if (redirect_s) begin
                pc_r <= redirect_pc_s;
            end else if (load_mem_s || load_buf_s) begin
                pc_r <= pc_inc(pc_r);
            end
            if (capture_buf_s) begin
                buf_r <= i_imem_data;
            end
            if (enter_drain_s) begin
                drain_addr_r <= pc_r;
            end
        end
    end

    // IF/ID register: bubble on flush or redirect, otherwise load or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifid_pc_r    <= 32'h0000_0000;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
        end else if (i_flush || redirect_s) begin
            ifid_pc_r    <= 32'h0000_0000;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
        end else if (load_mem_s) begin
            ifid_pc_r    <= pc_inc(pc_r);
            ifid_instr_r <= i_imem_data;
            ifid_valid_r <= 1'b1;
        end else if (load_buf_s) begin
            ifid_pc_r    <= pc_inc(pc_r);
            ifid_instr_r <= buf_r;
            ifid_valid_r <= 1'b1;
        end
    end

    assign o_pc     = ifid_pc_r;
    assign o_instr  = ifid_instr_r;
    assign o_valid  = ifid_valid_r;
    assign o_opcode = ifid_instr_r[31:26];
    assign o_Rs     = ifid_instr_r[25:21];
    assign o_Rt     = ifid_instr_r[20:16];
    assign o_Rd     = ifid_instr_r[15:11];
    assign o_imm    = ifid_instr_r[25:0];

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles spent waiting on instruction memory.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (o_imem_req && !i_imem_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_r;
`else
    assign o_stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed vectors for fetch; expected per-cycle observations are queued
// by the driver and compared by an independent negedge monitor.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [1:0]  pcsrc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic [31:0] stall_cnt;

    fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_pcsrc      (pcsrc),
        .i_nextPC     (next_pc),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_data  (imem_data),
        .i_imem_ready (imem_ready),
        .o_pc         (pc),
        .o_instr      (instr),
        .o_valid      (valid),
        .o_opcode     (opcode),
        .o_Rs         (rs),
        .o_Rt         (rt),
        .o_Rd         (rd),
        .o_imm        (imm),
        .o_stall_cnt  (stall_cnt)
    );

    typedef struct {
        int          tag;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total_checks = 0;
    int   pass_checks  = 0;
    int   step_no      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int tag, input string name, input logic [31:0] act, input logic [31:0] req);
        total_checks++;
        if (act === req) begin
            pass_checks++;
        end else begin
            $display("FAIL step %0d %s: got %h, expected %h", tag, name, act, req);
        end
    endtask

    // Monitor: one queued observation per cycle, sampled at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e.tag, "imem_req",  {31'd0, imem_req}, {31'd0, mon_e.req});
            check(mon_e.tag, "imem_addr", imem_addr, mon_e.addr);
            check(mon_e.tag, "pc",        pc, mon_e.pc);
            check(mon_e.tag, "instr",     instr, mon_e.instr);
            check(mon_e.tag, "valid",     {31'd0, valid}, {31'd0, mon_e.valid});
            check(mon_e.tag, "opcode",    {26'd0, opcode}, {26'd0, mon_e.instr[31:26]});
            check(mon_e.tag, "rs",        {27'd0, rs}, {27'd0, mon_e.instr[25:21]});
            check(mon_e.tag, "rt",        {27'd0, rt}, {27'd0, mon_e.instr[20:16]});
            check(mon_e.tag, "rd",        {27'd0, rd}, {27'd0, mon_e.instr[15:11]});
            check(mon_e.tag, "imm",       {6'd0, imm}, {6'd0, mon_e.instr[25:0]});
            check(mon_e.tag, "stall_cnt", stall_cnt, mon_e.cnt);
        end
    end

    // Drive one cycle of inputs and queue what must be visible during that cycle.
    task automatic step(input logic rst, input logic stl, input logic fl, input logic [1:0] src,
                        input logic [31:0] npc, input logic rdy, input logic [31:0] data,
                        input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                        input logic [31:0] e_instr, input logic e_valid, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = rst;
        stall      = stl;
        flush      = fl;
        pcsrc      = src;
        next_pc    = npc;
        imem_ready = rdy;
        imem_data  = data;
        e.tag   = step_no;
        e.req   = e_req;
        e.addr  = e_addr;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.valid = e_valid;
`ifdef FETCH_STALL_CNT_EN
        e.cnt   = e_cnt;
`else
        e.cnt   = 32'h0000_0000 & e_cnt & 32'h0000_0000;
`endif
        exp_q.push_back(e);
        step_no++;
    endtask

    initial begin
        rst_n      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        pcsrc      = 2'b00;
        next_pc    = 32'h0000_0000;
        imem_ready = 1'b0;
        imem_data  = 32'h0000_0000;
        #2 rst_n   = 1'b0;

        //   rst   stl   fl    src    npc           rdy   data            req   addr          pc            instr          vld   cnt
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b0, 32'h0,        32'h0,        NOP,           1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h2001_0005,  1'b1, 32'h0,        32'h0,        NOP,           1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h2001_0005,  1'b1, 32'h4,        32'h4,        32'h2001_0005, 1'b1, 32'd0);
        // memory wait at PC 8
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h8,        32'h8,        32'h2001_0005, 1'b1, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h8,        32'h8,        32'h2001_0005, 1'b1, 32'd1);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h8,        32'h8,        32'h2001_0005, 1'b1, 32'd2);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h0123_4567,  1'b1, 32'h8,        32'h8,        32'h2001_0005, 1'b1, 32'd3);
        // word returns under stall, buffered in HOLD
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0,        1'b1, 32'h8C22_0010,  1'b1, 32'hC,        32'hC,        32'h0123_4567, 1'b1, 32'd3);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0,        1'b0, 32'hFFFF_FFFF,  1'b0, 32'hC,        32'hC,        32'h0123_4567, 1'b1, 32'd3);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b0, 32'hC,        32'hC,        32'h0123_4567, 1'b1, 32'd3);
        // redirect while request outstanding: drain, then fetch 0x40
        step(1'b1, 1'b0, 1'b0, 2'b01, 32'h43,       1'b0, 32'h0,          1'b1, 32'h10,       32'h10,       32'h8C22_0010, 1'b1, 32'd3);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h10,       32'h0,        NOP,           1'b0, 32'd4);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'hBAD0_BAD0,  1'b1, 32'h10,       32'h0,        NOP,           1'b0, 32'd5);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h0000_1111,  1'b1, 32'h40,       32'h0,        NOP,           1'b0, 32'd5);
        // flush under stall
        step(1'b1, 1'b1, 1'b1, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h44,       32'h44,       32'h0000_1111, 1'b1, 32'd5);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h44,       32'h0,        NOP,           1'b0, 32'd6);
        // redirect with ready=1 to the top of the address space, then wrap
        step(1'b1, 1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 1'b1, 32'h5555_5555, 1'b1, 32'h44,       32'h0,        NOP,           1'b0, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h2222_3333,  1'b1, 32'hFFFF_FFFC, 32'h0,       NOP,           1'b0, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h1234_5678,  1'b1, 32'h0,        32'h0,        32'h2222_3333, 1'b1, 32'd7);
        // redirect during stall is ignored
        step(1'b1, 1'b1, 1'b0, 2'b01, 32'h100,      1'b1, 32'h7777_0000,  1'b1, 32'h4,        32'h4,        32'h1234_5678, 1'b1, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b0, 32'h4,        32'h4,        32'h1234_5678, 1'b1, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'hAAAA_0001,  1'b1, 32'h8,        32'h8,        32'h7777_0000, 1'b1, 32'd7);
        // redirect from HOLD discards the buffered word
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0,        1'b1, 32'h9999_0000,  1'b1, 32'hC,        32'hC,        32'hAAAA_0001, 1'b1, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b01, 32'h200,      1'b0, 32'h0,          1'b0, 32'hC,        32'hC,        32'hAAAA_0001, 1'b1, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h200,      32'h0,        NOP,           1'b0, 32'd7);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h200,      32'h0,        NOP,           1'b0, 32'd8);
        // reset mid-request, restart at RESET_PC
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b0, 32'h0,        32'h0,        NOP,           1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b1, 32'h0BAD_F00D,  1'b1, 32'h0,        32'h0,        NOP,           1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        1'b0, 32'h0,          1'b1, 32'h4,        32'h4,        32'h0BAD_F00D, 1'b1, 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        total_checks++;
        if (exp_q.size() == 0) begin
            pass_checks++;
        end else begin
            $display("FAIL drain: got %0d pending observations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
